// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write channel among per-thread LSUs.
// A single transaction is in flight at a time; every output is driven from a register.
module data_mem_arbiter #(
  parameter int NUM_CONSUMERS      = 4,
  parameter int DATA_MEM_ADDR_BITS = 8,
  parameter int DATA_MEM_DATA_BITS = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_CONSUMERS-1:0]                     consumer_read_valid,
  input  logic [NUM_CONSUMERS*DATA_MEM_ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                     consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_MEM_DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                     consumer_write_valid,
  input  logic [NUM_CONSUMERS*DATA_MEM_ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_MEM_DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                     consumer_write_ready,
  output logic                                         mem_read_valid,
  output logic [DATA_MEM_ADDR_BITS-1:0]                mem_read_address,
  input  logic                                         mem_read_ready,
  input  logic [DATA_MEM_DATA_BITS-1:0]                mem_read_data,
  output logic                                         mem_write_valid,
  output logic [DATA_MEM_ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_MEM_DATA_BITS-1:0]                mem_write_data,
  input  logic                                         mem_write_ready,
  output logic                                         busy
);

  localparam int N     = NUM_CONSUMERS;
  localparam int A     = DATA_MEM_ADDR_BITS;
  localparam int D     = DATA_MEM_DATA_BITS;
  localparam int IDX_W = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]   grant_r, grant_nxt_s;
  logic               is_write_r, is_write_nxt_s;
  logic [N-1:0]       read_ready_r, read_ready_nxt_s;
  logic [N-1:0]       write_ready_r, write_ready_nxt_s;
  logic [D-1:0]       read_data_r [N];
  logic [D-1:0]       read_data_nxt_s [N];
  logic               mem_read_valid_r, mem_read_valid_nxt_s;
  logic [A-1:0]       mem_read_address_r, mem_read_address_nxt_s;
  logic               mem_write_valid_r, mem_write_valid_nxt_s;
  logic [A-1:0]       mem_write_address_r, mem_write_address_nxt_s;
  logic [D-1:0]       mem_write_data_r, mem_write_data_nxt_s;
  logic               busy_r, busy_nxt_s;

  logic [N-1:0]       pending_s;
  logic               found_s;
  logic [IDX_W-1:0]   scan_idx_s;
  logic [IDX_W:0]     cand_s;
  logic               relay_valid_s;
  logic [A-1:0]       rd_addr_s [N];
  logic [A-1:0]       wr_addr_s [N];
  logic [D-1:0]       wr_data_s [N];

  // Unpack the flat per-consumer buses and pack the per-consumer read data.
  for (genvar gi = 0; gi < N; gi++) begin : g_lanes
    assign rd_addr_s[gi]                = consumer_read_address[gi*A +: A];
    assign wr_addr_s[gi]                = consumer_write_address[gi*A +: A];
    assign wr_data_s[gi]                = consumer_write_data[gi*D +: D];
    assign consumer_read_data[gi*D +: D] = read_data_r[gi];
  end

  assign pending_s            = consumer_read_valid | consumer_write_valid;
  assign consumer_read_ready  = read_ready_r;
  assign consumer_write_ready = write_ready_r;
  assign mem_read_valid       = mem_read_valid_r;
  assign mem_read_address     = mem_read_address_r;
  assign mem_write_valid      = mem_write_valid_r;
  assign mem_write_address    = mem_write_address_r;
  assign mem_write_data       = mem_write_data_r;
  assign busy                 = busy_r;

  // Round-robin scan: first pending consumer at or after rr_ptr, wrapping modulo N.
  always_comb begin
    found_s    = 1'b0;
    scan_idx_s = IDX_W'(0);
    cand_s     = (IDX_W+1)'(0);
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      if (cand_s >= (IDX_W+1)'(N)) begin
        cand_s = cand_s - (IDX_W+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && pending_s[cand_s[IDX_W-1:0]]) begin
        found_s    = 1'b1;
        scan_idx_s = cand_s[IDX_W-1:0];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // The valid that keeps the current grant parked in RELAY.
  always_comb begin
    if (is_write_r) begin
      relay_valid_s = consumer_write_valid[grant_r];
    end else begin
      relay_valid_s = consumer_read_valid[grant_r];
    end
  end

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    state_nxt_s             = state_r;
    rr_ptr_nxt_s            = rr_ptr_r;
    grant_nxt_s             = grant_r;
    is_write_nxt_s          = is_write_r;
    read_ready_nxt_s        = read_ready_r;
    write_ready_nxt_s       = write_ready_r;
    read_data_nxt_s         = read_data_r;
    mem_read_valid_nxt_s    = mem_read_valid_r;
    mem_read_address_nxt_s  = mem_read_address_r;
    mem_write_valid_nxt_s   = mem_write_valid_r;
    mem_write_address_nxt_s = mem_write_address_r;
    mem_write_data_nxt_s    = mem_write_data_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          grant_nxt_s = scan_idx_s;
          // A consumer asking for both is served its read first.
          if (consumer_read_valid[scan_idx_s]) begin
            is_write_nxt_s         = 1'b0;
            mem_read_valid_nxt_s   = 1'b1;
            mem_read_address_nxt_s = rd_addr_s[scan_idx_s];
            state_nxt_s            = READ_WAIT;
          end else begin
            is_write_nxt_s          = 1'b1;
            mem_write_valid_nxt_s   = 1'b1;
            mem_write_address_nxt_s = wr_addr_s[scan_idx_s];
            mem_write_data_nxt_s    = wr_data_s[scan_idx_s];
            state_nxt_s             = WRITE_WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_read_valid_nxt_s      = 1'b0;
          read_data_nxt_s[grant_r]  = mem_read_data;
          read_ready_nxt_s[grant_r] = 1'b1;
          state_nxt_s               = RELAY;
        end else begin
          state_nxt_s = READ_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_write_valid_nxt_s      = 1'b0;
          write_ready_nxt_s[grant_r] = 1'b1;
          state_nxt_s                = RELAY;
        end else begin
          state_nxt_s = WRITE_WAIT;
        end
      end
      RELAY: begin
        if (!relay_valid_s) begin
          read_ready_nxt_s  = {N{1'b0}};
          write_ready_nxt_s = {N{1'b0}};
          if (grant_r == IDX_W'(N - 1)) begin
            rr_ptr_nxt_s = IDX_W'(0);
          end else begin
            rr_ptr_nxt_s = grant_r + IDX_W'(1);
          end
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RELAY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and output registers; reset abandons any transaction without acknowledging it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r             <= IDLE;
      rr_ptr_r            <= IDX_W'(0);
      grant_r             <= IDX_W'(0);
      is_write_r          <= 1'b0;
      read_ready_r        <= {N{1'b0}};
      write_ready_r       <= {N{1'b0}};
      for (int i = 0; i < N; i++) begin
        read_data_r[i] <= D'(0);
      end
      mem_read_valid_r    <= 1'b0;
      mem_read_address_r  <= A'(0);
      mem_write_valid_r   <= 1'b0;
      mem_write_address_r <= A'(0);
      mem_write_data_r    <= D'(0);
      busy_r              <= 1'b0;
    end else begin
      state_r             <= state_nxt_s;
      rr_ptr_r            <= rr_ptr_nxt_s;
      grant_r             <= grant_nxt_s;
      is_write_r          <= is_write_nxt_s;
      read_ready_r        <= read_ready_nxt_s;
      write_ready_r       <= write_ready_nxt_s;
      read_data_r         <= read_data_nxt_s;
      mem_read_valid_r    <= mem_read_valid_nxt_s;
      mem_read_address_r  <= mem_read_address_nxt_s;
      mem_write_valid_r   <= mem_write_valid_nxt_s;
      mem_write_address_r <= mem_write_address_nxt_s;
      mem_write_data_r    <= mem_write_data_nxt_s;
      busy_r              <= busy_nxt_s;
    end
  end

endmodule
